soc_system_pio_poll_master: RTL and testbench
=============================================

// Module: soc_system_pio_poll_master
// PURPOSE
//  Avalon-MM read master that polls a 1-bit input PIO slave (data register at word address 0) every PERIOD clocks.
//  Registers the sampled bit, detects rising edges and keeps a wrapping event counter.
//  Sits in the FPGA fabric beside the HPS bridge and drives the PIO slave's s1 port through the interconnect.
//  Gives fabric logic edge counts with no HPS software involvement.
// PARAMETERS
//  PERIOD    1000  clocks between poll launches (>=1); counted from the return to IDLE
//  ADDR_W    2     avm_address width; issued address is always 0
//  BIT_SEL   0     readdata bit sampled (0..31)
//  CNT_W     16    edge_count width
//  TIMEOUT   64    max clocks waiting for readdatavalid (used only with POLL_TIMEOUT_EN)
// PORTS
//  clk                input   1       system clock
//  reset              input   1       synchronous, active-high reset
//  avm_address        output  ADDR_W  read address, constant 0
//  avm_read           output  1       read request
//  avm_waitrequest    input   1       slave stall; hold request while high
//  avm_readdata       input   32      read data
//  avm_readdatavalid  input   1       read data valid
//  enable             input   1       allow new polls
//  clear              input   1       zero edge_count
//  level              output  1       last sampled bit
//  sample_valid       output  1       1-clk pulse: level updated
//  rise_pulse         output  1       1-clk pulse: 0->1 seen between consecutive samples
//  edge_count         output  CNT_W   rising edges since reset/clear
//  timeout_err        output  1       sticky poll-timeout flag
// BEHAVIOUR
//  - Reset values: all outputs 0; FSM in IDLE; timer loaded with PERIOD-1; first-sample flag set.
//  - IDLE: timer decrements each clk; at 0 with enable=1 -> REQ. Timer reloads on entering IDLE.
//    With enable=0, timer holds at 0.
//  - REQ: avm_read=1, address held; stay while avm_waitrequest=1.
//    On an edge with waitrequest=0 -> WAIT; avm_read=0 from the next clk.
//  - WAIT: on avm_readdatavalid=1 -> IDLE.
//    At the next clk: level=readdata[BIT_SEL], sample_valid=1 for 1 clk.
//    rise_pulse=1 in the same clk if old level=0, new=1 and not first sample.
//    First-sample flag cleared.
//  - edge_count += 1 on rise_pulse; wraps 2^CNT_W-1 -> 0.
//    clear and rise_pulse in the same clk -> 0 (clear wins).
//  - enable dropping in REQ/WAIT: transaction completes normally; no further launch.
//  - reset mid-transaction: avm_read=0 at the next edge; any late readdatavalid is ignored.
//  - readdatavalid outside WAIT: ignored.
//  - Max 1 outstanding read; latency from launch = waitrequest stall + slave latency + 1.
// CONFIGURATION
//  POLL_TIMEOUT_EN defined:
//   - WAIT counts clocks; TIMEOUT clocks with no readdatavalid -> IDLE, timeout_err=1 (sticky).
//   - timeout_err cleared only by reset or clear; level is unchanged.
//  POLL_TIMEOUT_EN undefined: WAIT is unbounded; timeout_err tied 0; no timeout counter built.
// STRUCTURE
//  Package soc_system_poll_pkg: state encoding (IDLE, REQ, WAIT), AVM_DATA_W=32, POLL_ADDR=0.
//  Sub-module soc_system_poll_timer: loadable down-counter with zero flag, used for the PERIOD timer.
//  The timeout counter reuses a second instance of the same sub-module.
//  Edge detect, counter and FSM live in the top.
// TESTING
//  1 PERIOD=4, slave waitrequest=0, latency 1, input=0: avm_read pulses every 4+3 clks.
//    sample_valid each poll; edge_count=0.
//  2 Input 0->1 between polls: rise_pulse once, edge_count=1; input held 1 -> no further pulses.
//  3 waitrequest held high 5 clks: avm_read stays 1 for 6 clks, address=0; one sample results.
//  4 edge_count=0xFFFF, CNT_W=16, rising edge -> 0x0000.
//    clear asserted in the same clk as rise_pulse -> 0.
//  5 reset asserted during WAIT, then readdatavalid: no sample_valid; outputs 0.
//    First post-reset sample of 1 gives no rise_pulse.
//  6 POLL_TIMEOUT_EN, TIMEOUT=8, slave never returns data:
//    timeout_err=1 after 8 clks in WAIT, next poll proceeds; clear -> timeout_err=0.

Source files
------------

// File: rtl/soc_system_poll_pkg.sv
// Shared types and constants for the PIO poll master.
package soc_system_poll_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } poll_state_e;

  localparam int unsigned AVM_DATA_W = 32;
  localparam int unsigned POLL_ADDR  = 0;

  // The first sample after reset has no valid predecessor, so it never counts as an edge.
  function automatic logic is_rise(input logic old_lvl, input logic new_lvl, input logic first);
    return !first && !old_lvl && new_lvl;
  endfunction

endpackage

// File: rtl/soc_system_poll_timer.sv
// Loadable saturating down-counter with a registered zero flag.
module soc_system_poll_timer #(
  parameter int unsigned W       = 1,
  parameter int unsigned RST_VAL = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         zero_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= W'(RST_VAL);
      zero_q <= (RST_VAL == 0);
    end else begin
      cnt_q  <= cnt_d;
      zero_q <= (cnt_d == '0);
    end
  end

  assign zero_o = zero_q;

endmodule

// File: rtl/soc_system_pio_poll_master.sv
// Avalon-MM read master polling a 1-bit PIO, with edge detect and edge counter.
// Define POLL_TIMEOUT_EN to bound the wait for readdatavalid and flag timeouts.
module soc_system_pio_poll_master
  import soc_system_poll_pkg::*;
#(
  parameter int unsigned PERIOD  = 1000,
  parameter int unsigned ADDR_W  = 2,
  parameter int unsigned BIT_SEL = 0,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [ADDR_W-1:0]     avm_address,
  output logic                  avm_read,
  input  logic                  avm_waitrequest,
  input  logic [AVM_DATA_W-1:0] avm_readdata,
  input  logic                  avm_readdatavalid,
  input  logic                  enable,
  input  logic                  clear,
  output logic                  level,
  output logic                  sample_valid,
  output logic                  rise_pulse,
  output logic [CNT_W-1:0]      edge_count,
  output logic                  timeout_err
);

  localparam int unsigned PER_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  poll_state_e       state_q, state_d;
  logic              avm_read_q, avm_read_d;
  logic              level_q, level_d;
  logic              sample_valid_q, sample_valid_d;
  logic              rise_q, rise_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              first_q, first_d;
  logic              reload_q, reload_d;
  logic              sample_c;
  logic              accept_c;
  logic              per_zero;
  logic              new_bit;
  logic              unused_sig;

  assign new_bit = avm_readdata[BIT_SEL];

  // Period timer: reloaded in the first IDLE clock, so its stale zero is ignored there.
  soc_system_poll_timer #(
    .W       (PER_W),
    .RST_VAL (PERIOD - 1)
  ) u_period_timer (
    .clk        (clk),
    .reset      (reset),
    .load_i     (reload_q),
    .load_val_i (PER_W'(PERIOD - 1)),
    .dec_i      ((state_q == ST_IDLE) && !reload_q),
    .zero_o     (per_zero)
  );

`ifdef POLL_TIMEOUT_EN
  localparam int unsigned TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic tmo_zero;
  logic tmo_c;
  logic tmo_err_q, tmo_err_d;

  soc_system_poll_timer #(
    .W       (TO_W),
    .RST_VAL (TIMEOUT - 1)
  ) u_timeout_timer (
    .clk        (clk),
    .reset      (reset),
    .load_i     (accept_c),
    .load_val_i (TO_W'(TIMEOUT - 1)),
    .dec_i      (state_q == ST_WAIT),
    .zero_o     (tmo_zero)
  );

  always_comb begin
    tmo_err_d = tmo_err_q;
    if (clear) begin
      tmo_err_d = 1'b0;
    end else if (tmo_c) begin
      tmo_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_err_q <= 1'b0;
    end else begin
      tmo_err_q <= tmo_err_d;
    end
  end

  assign timeout_err = tmo_err_q;
  assign unused_sig  = ^avm_readdata;
`else
  assign timeout_err = 1'b0;
  assign unused_sig  = ^{avm_readdata, 32'(TIMEOUT)};
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    sample_c = 1'b0;
    accept_c = 1'b0;
`ifdef POLL_TIMEOUT_EN
    tmo_c    = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (per_zero && !reload_q && enable) begin
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (!avm_waitrequest) begin
          state_d  = ST_WAIT;
          accept_c = 1'b1;
        end
      end
      ST_WAIT: begin
        if (avm_readdatavalid) begin
          state_d  = ST_IDLE;
          sample_c = 1'b1;
        end
`ifdef POLL_TIMEOUT_EN
        else if (tmo_zero) begin
          state_d = ST_IDLE;
          tmo_c   = 1'b1;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase

    avm_read_d     = (state_d == ST_REQ);
    reload_d       = (state_d == ST_IDLE) && (state_q != ST_IDLE);
    sample_valid_d = sample_c;
    level_d        = sample_c ? new_bit : level_q;
    rise_d         = sample_c && is_rise(level_q, new_bit, first_q);
    first_d        = sample_c ? 1'b0 : first_q;

    // Clear beats a simultaneous rise.
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (rise_q) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      avm_read_q     <= 1'b0;
      level_q        <= 1'b0;
      sample_valid_q <= 1'b0;
      rise_q         <= 1'b0;
      count_q        <= '0;
      first_q        <= 1'b1;
      reload_q       <= 1'b0;
    end else begin
      avm_read_q     <= avm_read_d;
      level_q        <= level_d;
      sample_valid_q <= sample_valid_d;
      rise_q         <= rise_d;
      count_q        <= count_d;
      first_q        <= first_d;
      reload_q       <= reload_d;
    end
  end

  assign avm_address  = ADDR_W'(POLL_ADDR);
  assign avm_read     = avm_read_q;
  assign level        = level_q;
  assign sample_valid = sample_valid_q;
  assign rise_pulse   = rise_q;
  assign edge_count   = count_q;

endmodule

// File: tb/tb_soc_system_pio_poll_master.sv
// Scoreboard bench for soc_system_pio_poll_master with a behavioural Avalon PIO slave.
module tb_soc_system_pio_poll_master;

  localparam int unsigned PERIOD  = 4;
  localparam int unsigned TIMEOUT = 8;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned BIT_SEL = 3;
  localparam int unsigned ADDR_W  = 2;

  logic              clk;
  logic              reset;
  logic              avm_waitrequest;
  logic              avm_readdatavalid;
  logic [31:0]       avm_readdata;
  logic              enable;
  logic              clear;
  logic [ADDR_W-1:0] avm_address, avm_address_w;
  logic              avm_read, level, sample_valid, rise_pulse, timeout_err;
  logic [CNT_W-1:0]  edge_count;
  logic              avm_read_w, level_w, sample_valid_w, rise_pulse_w, timeout_err_w;
  logic [2:0]        edge_count_w;

  typedef struct packed {
    logic lvl;
    logic rise;
  } exp_t;

  exp_t             sb_q[$];
  int               checks = 0;
  int               errors = 0;
  logic             m_level = 1'b0;
  logic             m_first = 1'b1;
  logic [CNT_W-1:0] exp_cnt = '0;
  logic [2:0]       exp_cnt_w = '0;

  int stall_n = 0, stall_left = 0;
  bit respond = 1'b1, pin = 1'b0, accepted = 1'b0, rd_active = 1'b0;
  bit in_wait = 1'b0, inject_rdv = 1'b0, clear_on_rise = 1'b0, mon_clear = 1'b0;
  int cyc = 0, n_samples = 0, launches = 0, last_launch = 0, launch_gap = 0;
  int read_start = 0, read_len = 0, accept_cyc = 0;
  logic prev_read = 1'b0;

  soc_system_pio_poll_master #(
    .PERIOD (PERIOD), .ADDR_W (ADDR_W), .BIT_SEL (BIT_SEL), .CNT_W (CNT_W), .TIMEOUT (TIMEOUT)
  ) dut (
    .clk (clk), .reset (reset), .avm_address (avm_address), .avm_read (avm_read),
    .avm_waitrequest (avm_waitrequest), .avm_readdata (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid), .enable (enable), .clear (clear),
    .level (level), .sample_valid (sample_valid), .rise_pulse (rise_pulse),
    .edge_count (edge_count), .timeout_err (timeout_err)
  );

  // Narrow-counter twin on the same bus traffic, to exercise counter wrap quickly.
  soc_system_pio_poll_master #(
    .PERIOD (PERIOD), .ADDR_W (ADDR_W), .BIT_SEL (BIT_SEL), .CNT_W (3), .TIMEOUT (TIMEOUT)
  ) dut_w3 (
    .clk (clk), .reset (reset), .avm_address (avm_address_w), .avm_read (avm_read_w),
    .avm_waitrequest (avm_waitrequest), .avm_readdata (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid), .enable (enable), .clear (clear),
    .level (level_w), .sample_valid (sample_valid_w), .rise_pulse (rise_pulse_w),
    .edge_count (edge_count_w), .timeout_err (timeout_err_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic wait_samples(input int n);
    int target;
    int budget;
    target = n_samples + n;
    budget = n * int'(PERIOD + TIMEOUT + 30) + 40;
    while ((n_samples < target) && (budget > 0)) begin
      @(posedge clk);
      budget--;
    end
    if (n_samples < target) check_eq("sample_wait", 32'(n_samples), 32'(target));
  endtask

  task automatic settle();
    repeat (2) @(posedge clk);
    @(negedge clk);
  endtask

  // Slave model: stalls, returns data one clock after acceptance, predicts the sample.
  initial begin
    avm_waitrequest   = 1'b0;
    avm_readdatavalid = 1'b0;
    avm_readdata      = '0;
    forever begin
      @(posedge clk);
      #1;
      avm_readdatavalid = 1'b0;
      avm_readdata      = $urandom;
      if (reset) begin
        accepted        = 1'b0;
        rd_active       = 1'b0;
        in_wait         = 1'b0;
        avm_waitrequest = 1'b0;
      end else begin
        if (accepted) begin
          accepted = 1'b0;
          if (respond) begin
            avm_readdatavalid     = 1'b1;
            avm_readdata[BIT_SEL] = pin;
            sb_q.push_back('{lvl: pin, rise: (!m_first && !m_level && pin)});
            m_level = pin;
            m_first = 1'b0;
          end else begin
            in_wait = 1'b1;
          end
        end
        if (avm_read) begin
          if (!rd_active) begin
            rd_active  = 1'b1;
            stall_left = stall_n;
          end
          if (stall_left > 0) begin
            avm_waitrequest = 1'b1;
            stall_left--;
          end else begin
            avm_waitrequest = 1'b0;
            accepted        = 1'b1;
            rd_active       = 1'b0;
            accept_cyc      = cyc + 1;
          end
        end else begin
          avm_waitrequest = 1'b0;
        end
      end
      if (inject_rdv) begin
        avm_readdatavalid     = 1'b1;
        avm_readdata[BIT_SEL] = 1'b1;
        inject_rdv            = 1'b0;
      end
    end
  end

  // Monitor: pops predictions on each sample and tracks launches and read lengths.
  initial begin
    exp_t e;
    bit   rise_now;
    forever begin
      @(negedge clk);
      cyc++;
      if (mon_clear) begin
        clear     = 1'b0;
        mon_clear = 1'b0;
      end
      rise_now = 1'b0;
      if (sample_valid) begin
        if (sb_q.size() == 0) begin
          check_eq("spurious_sample", 32'(sample_valid), 32'd0);
        end else begin
          e = sb_q.pop_front();
          check_eq("level", 32'(level), 32'(e.lvl));
          check_eq("rise", 32'(rise_pulse), 32'(e.rise));
          check_eq("count", 32'(edge_count), 32'(exp_cnt));
          check_eq("level_w3", 32'(level_w), 32'(e.lvl));
          check_eq("count_w3", 32'(edge_count_w), 32'(exp_cnt_w));
          n_samples++;
          rise_now = e.rise;
        end
      end else if (rise_pulse) begin
        check_eq("stray_rise", 32'(rise_pulse), 32'd0);
      end
      if (clear_on_rise && rise_now) begin
        clear         = 1'b1;
        clear_on_rise = 1'b0;
        mon_clear     = 1'b1;
      end
      if (clear) begin
        exp_cnt   = '0;
        exp_cnt_w = '0;
      end else if (rise_now) begin
        exp_cnt   = exp_cnt + 1'b1;
        exp_cnt_w = exp_cnt_w + 1'b1;
      end
      if (avm_read && !prev_read) begin
        launches++;
        launch_gap  = cyc - last_launch;
        last_launch = cyc;
        read_start  = cyc;
        check_eq("addr", 32'(avm_address), 32'd0);
      end
      if (!avm_read && prev_read) read_len = cyc - read_start;
      prev_read = avm_read;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired @%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int l0;
    int s0;
    int b;
    reset  = 1'b1;
    enable = 1'b0;
    clear  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_read", 32'(avm_read), 32'd0);
    check_eq("rst_level", 32'(level), 32'd0);
    check_eq("rst_valid", 32'(sample_valid), 32'd0);
    check_eq("rst_count", 32'(edge_count), 32'd0);
    check_eq("rst_tmo", 32'(timeout_err), 32'd0);
    @(posedge clk);
    #2 reset = 1'b0;
    enable = 1'b1;

    // Input low, no stall: steady poll spacing and no edges.
    wait_samples(3);
    check_eq("gap_idle", 32'(launch_gap), 32'(PERIOD + 3));
    check_eq("cnt_low", 32'(edge_count), 32'd0);

    // Input goes high once.
    pin = 1'b1;
    wait_samples(1);
    settle();
    check_eq("cnt_rise", 32'(edge_count), 32'd1);
    wait_samples(2);
    settle();
    check_eq("cnt_hold", 32'(edge_count), 32'd1);

    // Five clocks of waitrequest.
    stall_n = 5;
    wait_samples(1);
    check_eq("stall_len", 32'(read_len), 32'd6);
    stall_n = 0;

    // Enable low while idle: no launches.
    @(posedge clk);
    #2 enable = 1'b0;
    l0 = launches;
    repeat (30) @(posedge clk);
    check_eq("en_off_idle", 32'(launches), 32'(l0));

    // Enable dropped during a request: it completes, nothing follows.
    #2 enable = 1'b1;
    b = 50;
    while (!avm_read && (b > 0)) begin
      @(posedge clk);
      #2;
      b--;
    end
    check_eq("en_launch_seen", 32'(avm_read), 32'd1);
    enable = 1'b0;
    l0 = launches;
    s0 = n_samples;
    repeat (30) @(posedge clk);
    check_eq("en_off_req_launch", 32'(launches), 32'(l0 + 1));
    check_eq("en_off_req_sample", 32'(n_samples), 32'(s0 + 1));
    #2 enable = 1'b1;

    // Eight rising edges: wide counter 1->9, 3-bit twin wraps 7->0->1.
    for (int i = 0; i < 8; i++) begin
      pin = 1'b0;
      wait_samples(1);
      pin = 1'b1;
      wait_samples(1);
    end
    settle();
    check_eq("wrap16", 32'(edge_count), 32'd9);
    check_eq("wrap_w3", 32'(edge_count_w), 32'd1);

    // Clear in the same clock as a rise pulse.
    pin = 1'b0;
    wait_samples(1);
    pin = 1'b1;
    clear_on_rise = 1'b1;
    wait_samples(1);
    settle();
    check_eq("clr_rise", 32'(edge_count), 32'd0);
    check_eq("clr_rise_w3", 32'(edge_count_w), 32'd0);

    pin = 1'b0;
    wait_samples(1);
    pin = 1'b1;
    wait_samples(1);
    settle();
    check_eq("pre_rst_count", 32'(edge_count), 32'd1);

    // Reset while waiting for data, then a late readdatavalid.
    respond = 1'b0;
    in_wait = 1'b0;
    b = 60;
    while (!in_wait && (b > 0)) begin
      @(posedge clk);
      #2;
      b--;
    end
    check_eq("rst_in_wait", 32'(in_wait), 32'd1);
    reset      = 1'b1;
    inject_rdv = 1'b1;
    sb_q.delete();
    m_level   = 1'b0;
    m_first   = 1'b1;
    exp_cnt   = '0;
    exp_cnt_w = '0;
    @(posedge clk);
    #2 reset = 1'b0;
    respond = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_read", 32'(avm_read), 32'd0);
    check_eq("mid_rst_level", 32'(level), 32'd0);
    check_eq("mid_rst_count", 32'(edge_count), 32'd0);
    @(negedge clk);
    check_eq("late_rdv_valid", 32'(sample_valid), 32'd0);
    wait_samples(2);
    settle();
    check_eq("post_rst_count", 32'(edge_count), 32'd0);
    check_eq("post_rst_level", 32'(level), 32'd1);

`ifdef POLL_TIMEOUT_EN
    // Slave never answers: timeout after TIMEOUT clocks in WAIT.
    respond = 1'b0;
    b = 100;
    while (!timeout_err && (b > 0)) begin
      @(negedge clk);
      #1;
      b--;
    end
    check_eq("tmo_set", 32'(timeout_err), 32'd1);
    check_eq("tmo_lat", 32'(cyc - accept_cyc), 32'(TIMEOUT + 1));
    check_eq("tmo_level", 32'(level), 32'd1);
    respond = 1'b1;
    wait_samples(1);
    check_eq("tmo_sticky", 32'(timeout_err), 32'd1);
    @(posedge clk);
    #2 clear = 1'b1;
    @(posedge clk);
    #2 clear = 1'b0;
    @(negedge clk);
    check_eq("tmo_clr", 32'(timeout_err), 32'd0);
`else
    repeat (5) @(posedge clk);
    @(negedge clk);
    check_eq("tmo_tied", 32'(timeout_err), 32'd0);
`endif

    wait_samples(1);
    settle();
    check_eq("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
